// File: rtl/pc_pkg.sv
// Shared next-PC selector definitions: PCSource encodings and default sizing.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'd0,
        PCSRC_BRANCH = 2'd1,
        PCSRC_JUMP   = 2'd2,
        PCSRC_REG    = 2'd3
    } pc_src_e;

endpackage

// File: rtl/mx_pc_source_if.sv
// Bus bundle between the PC control logic (master) and the next-PC selector (slave).
interface mx_pc_source_if #(
    parameter int unsigned WIDTH = pc_pkg::PC_WIDTH
);
    logic [1:0]       PCSource;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       sel_q;
    logic             misaligned;

    modport master (
        output PCSource, in0, in1, in2, in3,
        input  out, out_q, sel_q, misaligned
    );

    modport slave (
        input  PCSource, in0, in1, in2, in3,
        output out, out_q, sel_q, misaligned
    );
endinterface

// File: rtl/mx_pc_source_mux4.sv
// Generic 4:1 WIDTH-bit combinational selector; also reused by ALU-source and write-back muxes.
module mx_pc_source_mux4
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    // An unknown select in simulation falls to the default arm and passes d0.
    always_comb begin
        y = d0;
        case (sel)
            PCSRC_BRANCH: y = d1;
            PCSRC_JUMP:   y = d2;
            PCSRC_REG:    y = d3;
            default:      y = d0;
        endcase
    end

endmodule

// File: rtl/mx_pc_source.sv
// Next-PC source selector: combinational 4:1 mux, registered debug copy and misalignment flag.
module mx_pc_source
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic          clk,
    input  logic          rst,
    mx_pc_source_if.slave pc
);

    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] out_q_reg;
    logic [1:0]       sel_q_reg;

    mx_pc_source_mux4 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (pc.PCSource),
        .d0  (pc.in0),
        .d1  (pc.in1),
        .d2  (pc.in2),
        .d3  (pc.in3),
        .y   (out_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_reg <= RESET_VECTOR;
            sel_q_reg <= PCSRC_SEQ;
        end else begin
            out_q_reg <= out_next;
            sel_q_reg <= pc.PCSource;
        end
    end

    // Only the low two bits matter for word alignment; reset deliberately not involved.
    assign pc.out        = out_next;
    assign pc.misaligned = out_next[1] | out_next[0];
    assign pc.out_q      = out_q_reg;
    assign pc.sel_q      = sel_q_reg;

endmodule

// File: tb/tb_mx_pc_source.sv
// Self-checking bench for mx_pc_source: vector table, corner sequences and randomized model check.
module tb_mx_pc_source;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mx_pc_source_if #(.WIDTH(32)) pc ();

    mx_pc_source #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pc  (pc)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] d0, d1, d2, d3;
        logic [31:0] exp_out;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [31:0] a, b, c, d);
        pc.PCSource = s;
        pc.in0 = a;
        pc.in1 = b;
        pc.in2 = c;
        pc.in3 = d;
    endtask

    initial begin
        logic [31:0] ins[4];
        logic [31:0] exp_q;
        logic [1:0]  exp_s;
        logic        do_rst;

        vecs[0] = '{2'd0, 32'h0000_0004, 32'h0000_0100, 32'h0040_0000, 32'h8000_0180, 32'h0000_0004, 1'b0};
        vecs[1] = '{2'd1, 32'h0000_0004, 32'h0000_0100, 32'h0040_0000, 32'h8000_0180, 32'h0000_0100, 1'b0};
        vecs[2] = '{2'd2, 32'h0000_0004, 32'h0000_0100, 32'h0040_0000, 32'h8000_0180, 32'h0040_0000, 1'b0};
        vecs[3] = '{2'd3, 32'h0000_0004, 32'h0000_0100, 32'h0040_0000, 32'h8000_0180, 32'h8000_0180, 1'b0};
        vecs[4] = '{2'd3, 32'h0000_0004, 32'h0000_0100, 32'h0040_0000, 32'h8000_0182, 32'h8000_0182, 1'b1};
        vecs[5] = '{2'd0, 32'hFFFF_FFFD, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFD, 1'b1};

        // Reset with all inputs zero
        drive(2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_out", pc.out, 32'h0);
        chk("reset_out_q", pc.out_q, 32'h0);
        chk("reset_sel_q", {30'h0, pc.sel_q}, 32'h0);
        chk("reset_mis", {31'h0, pc.misaligned}, 32'h0);
        $display("reset: out=%08h out_q=%08h sel_q=%0d", pc.out, pc.out_q, pc.sel_q);

        // Table: combinational select, then registered copy after the edge
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].sel, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
            #1;
            chk("vec_out", pc.out, vecs[i].exp_out);
            chk("vec_mis", {31'h0, pc.misaligned}, {31'h0, vecs[i].exp_mis});
            tick();
            chk("vec_out_q", pc.out_q, vecs[i].exp_out);
            chk("vec_sel_q", {30'h0, pc.sel_q}, {30'h0, vecs[i].sel});
            $display("vec %0d: sel=%0d out=%08h mis=%0b out_q=%08h", i, vecs[i].sel, pc.out, pc.misaligned, pc.out_q);
        end

        // Isolation: unselected inputs must not reach out
        drive(2'd1, 32'h0000_0004, 32'h0000_0100, 32'h0040_0000, 32'h8000_0180);
        #1;
        pc.in0 = 32'hFFFF_FFFF;
        #1;
        chk("iso_in0", pc.out, 32'h0000_0100);
        pc.in2 = 32'hFFFF_FFFF;
        #1;
        chk("iso_in2", pc.out, 32'h0000_0100);
        pc.in3 = 32'hFFFF_FFFF;
        #1;
        chk("iso_in3", pc.out, 32'h0000_0100);
        $display("isolation: out=%08h", pc.out);

        // Reset mid-run
        drive(2'd2, 32'h0000_0004, 32'h0000_0100, 32'h0040_0000, 32'h8000_0180);
        tick();
        chk("mid_pre_q", pc.out_q, 32'h0040_0000);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", pc.out, 32'h0040_0000);
        chk("mid_rst_hold_q", pc.out_q, 32'h0040_0000);
        tick();
        chk("mid_rst_q", pc.out_q, 32'h0);
        chk("mid_rst_sel", {30'h0, pc.sel_q}, 32'h0);
        pc.PCSource = 2'd3;
        #1;
        chk("mid_rst_track", pc.out, 32'h8000_0180);
        rst = 1'b0;
        $display("reset mid-run: out_q=%08h sel_q=%0d out=%08h", pc.out_q, pc.sel_q, pc.out);

        // Randomized: model keeps inputs in an array and indexes by select
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 4; k++) ins[k] = $urandom;
            exp_s  = 2'($urandom_range(0, 3));
            do_rst = ($urandom_range(0, 31) == 0);
            drive(exp_s, ins[0], ins[1], ins[2], ins[3]);
            rst = do_rst;
            #1;
            chk("rnd_out", pc.out, ins[exp_s]);
            chk("rnd_mis", {31'h0, pc.misaligned}, {31'h0, (ins[exp_s] % 4) != 0});
            exp_q = do_rst ? 32'h0 : ins[exp_s];
            tick();
            chk("rnd_out_q", pc.out_q, exp_q);
            chk("rnd_sel_q", {30'h0, pc.sel_q}, do_rst ? 32'h0 : {30'h0, exp_s});
            if (n % 100 == 0)
                $display("rnd %0d: sel=%0d rst=%0b out=%08h out_q=%08h", n, exp_s, do_rst, ins[exp_s], pc.out_q);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
